// File: rtl/node_inject_scheduler_pkg.sv
// Shared configuration, packet layout and helpers for the node injection path.
// The network-wide constants keep their historical macro names so older
// code that still uses the macros stays consistent with this package.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef N
`define N (`X_NODES * `Y_NODES)
`endif
`ifndef CREATE_ANT_PERIOD
`define CREATE_ANT_PERIOD 16
`endif
`ifndef NODE_QUEUE_DEPTH
`define NODE_QUEUE_DEPTH 8
`endif

package node_inject_scheduler_pkg;

  localparam int unsigned X_NODES           = `X_NODES;
  localparam int unsigned Y_NODES           = `Y_NODES;
  localparam int unsigned N_NODES           = `N;
  localparam int unsigned CREATE_ANT_PERIOD = `CREATE_ANT_PERIOD;
  localparam int unsigned NODE_QUEUE_DEPTH  = `NODE_QUEUE_DEPTH;

  localparam int unsigned XW     = (X_NODES > 1) ? $clog2(X_NODES) : 1;
  localparam int unsigned YW     = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned MEAS_W = 16;
  localparam int unsigned NM_W   = $clog2(N_NODES + 1);

  typedef struct packed {
    logic                  ant;
    logic                  backward;
    logic [XW-1:0]         x_dest;
    logic [YW-1:0]         y_dest;
    logic [XW-1:0]         x_source;
    logic [YW-1:0]         y_source;
    logic [ID_W-1:0]       id;
    logic [TS_W-1:0]       timestamp;
    logic [MEAS_W-1:0]     measure;
    logic [N_NODES*XW-1:0] x_memory;
    logic [N_NODES*YW-1:0] y_memory;
    logic [NM_W-1:0]       num_memories;
    logic [N_NODES*XW-1:0] b_x_memory;
    logic [N_NODES*YW-1:0] b_y_memory;
    logic [NM_W-1:0]       b_num_memories;
  } packet_t;

  // Only the source-supplied fields are buffered; everything else is stamped
  // when the packet is loaded into the output register.
  typedef struct packed {
    logic [XW-1:0]     x_dest;
    logic [YW-1:0]     y_dest;
    logic [MEAS_W-1:0] measure;
  } gen_entry_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } coord_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Raster step over the mesh: x first, then y, both wrapping.
  function automatic coord_t raster_next(input coord_t c);
    coord_t n;
    n = c;
    if (c.x == XW'(X_NODES - 1)) begin
      n.x = '0;
      n.y = (c.y == YW'(Y_NODES - 1)) ? '0 : c.y + 1'b1;
    end else begin
      n.x = c.x + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/node_inject_scheduler_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only
// when a pop happens on the same edge.
module inject_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // Occupancy and accept decisions
  always_comb begin
    count = wr_ptr - rd_ptr;
    full  = (count == (AW + 1)'(DEPTH));
    empty = (count == '0);
    rd_en = pop && !empty;
    wr_en = push && (!full || rd_en);
    dout  = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/node_inject_scheduler.sv
// Node injection scheduler: buffers source data, generates periodic ants and
// arbitrates both onto one registered output feeding router port 0.
module node_inject_scheduler
  import node_inject_scheduler_pkg::*;
#(
  parameter int unsigned X_LOC       = 0,
  parameter int unsigned Y_LOC       = 0,
  parameter int unsigned QUEUE_DEPTH = NODE_QUEUE_DEPTH,
  parameter int unsigned ANT_PERIOD  = CREATE_ANT_PERIOD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  packet_t     i_gen_data,
  input  logic        i_gen_val,
  output logic        o_full,
  output packet_t     o_data,
  output logic        o_data_val,
  input  logic        i_en,
  output logic [15:0] o_drop_count,
  output logic [15:0] o_ant_miss,
  output logic [31:0] o_inject_count
);

  localparam int unsigned TW   = (ANT_PERIOD > 1) ? $clog2(ANT_PERIOD) : 1;
  localparam int unsigned EW   = $bits(gen_entry_t);
  localparam coord_t      SELF = '{x: XW'(X_LOC), y: YW'(Y_LOC)};

  state_e     state;
  state_e     state_nxt;
  gen_entry_t push_entry;
  gen_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       drop;
  logic [TW-1:0]   ant_timer;
  logic            ant_tick;
  logic            ant_pending;
  logic            ant_last;
  coord_t          ant_ctr;
  coord_t          ant_dest;
  coord_t          ant_ctr_nxt;
  logic [ID_W-1:0] id_ctr;
  logic [TS_W-1:0] cyc_ctr;
  logic            xfer;
  logic            sel_ant;
  logic            cand_valid;
  logic            load;
  logic            ant_load;
  packet_t         cand_pkt;
  packet_t         data_q;
  logic            unused_gen_fields;

  assign push_entry = '{x_dest: i_gen_data.x_dest, y_dest: i_gen_data.y_dest,
                        measure: i_gen_data.measure};
  assign unused_gen_fields = ^i_gen_data;

  inject_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (i_gen_val),
    .din     (push_entry),
    .pop     (fifo_pop),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Arbitration: an ant wins unless the previous load was an ant and data waits
  always_comb begin
    xfer       = (state == ST_HOLD) && i_en;
    sel_ant    = ant_pending && (fifo_empty || !ant_last);
    cand_valid = sel_ant || !fifo_empty;
    load       = cand_valid && ((state == ST_EMPTY) || xfer);
    ant_load   = load && sel_ant;
    fifo_pop   = load && !sel_ant;
    drop       = i_gen_val && fifo_full && !fifo_pop;
    ant_tick   = (ant_timer == TW'(ANT_PERIOD - 1));
  end

  // Ant destination: the reset value may equal self, so skip it on use too
  always_comb begin
    ant_dest    = (ant_ctr == SELF) ? raster_next(ant_ctr) : ant_ctr;
    ant_ctr_nxt = raster_next(ant_dest);
    if (ant_ctr_nxt == SELF) ant_ctr_nxt = raster_next(ant_ctr_nxt);
  end

  // Candidate packet with stamped source, id and timestamp
  always_comb begin
    cand_pkt = '0;
    if (sel_ant) begin
      cand_pkt.ant    = 1'b1;
      cand_pkt.x_dest = ant_dest.x;
      cand_pkt.y_dest = ant_dest.y;
    end else begin
      cand_pkt.x_dest  = head.x_dest;
      cand_pkt.y_dest  = head.y_dest;
      cand_pkt.measure = head.measure;
    end
    cand_pkt.x_source  = SELF.x;
    cand_pkt.y_source  = SELF.y;
    cand_pkt.id        = id_ctr;
    cand_pkt.timestamp = cyc_ctr;
  end

  // Output register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  // Output register next state; a transfer reloads on the same edge
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: if (cand_valid) state_nxt = ST_HOLD;
      ST_HOLD:  if (xfer && !cand_valid) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Output drive
  always_comb begin
    o_data_val = (state == ST_HOLD);
    o_data     = data_q;
    o_full     = fifo_full;
  end

  // Held packet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  data_q <= '0;
    else if (load) data_q <= cand_pkt;
  end

  // Ant timer, pending flag, fairness flag and destination counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ant_timer   <= '0;
      ant_pending <= 1'b0;
      ant_last    <= 1'b0;
      ant_ctr     <= '0;
      o_ant_miss  <= '0;
    end else begin
      ant_timer <= ant_tick ? '0 : ant_timer + 1'b1;
      if (ant_tick) begin
        ant_pending <= 1'b1;
        if (ant_pending && !ant_load && (o_ant_miss != '1))
          o_ant_miss <= o_ant_miss + 1'b1;
      end else if (ant_load) begin
        ant_pending <= 1'b0;
      end
      if (load) ant_last <= sel_ant;
      if (ant_load) ant_ctr <= ant_ctr_nxt;
    end
  end

  // Id, cycle and statistics counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ctr         <= '0;
      cyc_ctr        <= '0;
      o_drop_count   <= '0;
      o_inject_count <= '0;
    end else begin
      cyc_ctr <= cyc_ctr + 1'b1;
      if (load) id_ctr <= id_ctr + 1'b1;
      if (xfer) o_inject_count <= o_inject_count + 1'b1;
      if (drop && (o_drop_count != '1)) o_drop_count <= o_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_node_inject_scheduler.sv
// Directed bench for node_inject_scheduler with a queue-based reference model.
module tb_node_inject_scheduler;
  import node_inject_scheduler_pkg::*;

  localparam int unsigned XL = 2;
  localparam int unsigned YL = 1;
  localparam int unsigned QD = 4;
  localparam int unsigned AP = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  packet_t     i_gen_data = '0;
  logic        i_gen_val = 1'b0;
  logic        i_en = 1'b0;
  logic        o_full;
  packet_t     o_data;
  logic        o_data_val;
  logic [15:0] o_drop_count;
  logic [15:0] o_ant_miss;
  logic [31:0] o_inject_count;

  node_inject_scheduler #(
    .X_LOC       (XL),
    .Y_LOC       (YL),
    .QUEUE_DEPTH (QD),
    .ANT_PERIOD  (AP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_gen_data     (i_gen_data),
    .i_gen_val      (i_gen_val),
    .o_full         (o_full),
    .o_data         (o_data),
    .o_data_val     (o_data_val),
    .i_en           (i_en),
    .o_drop_count   (o_drop_count),
    .o_ant_miss     (o_ant_miss),
    .o_inject_count (o_inject_count)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  packet_t     m_q[$];
  packet_t     m_hold;
  bit          m_hold_v;
  bit          m_pend;
  bit          m_ant_last;
  int unsigned m_cyc, m_id, m_ant_n, m_drop, m_miss, m_inject;
  int unsigned ant_x[$];
  int unsigned ant_y[$];

  // Destinations in visiting order: raster over the mesh minus this node
  initial begin
    for (int unsigned y = 0; y < Y_NODES; y++)
      for (int unsigned x = 0; x < X_NODES; x++)
        if (!(x == XL && y == YL)) begin
          ant_x.push_back(x);
          ant_y.push_back(y);
        end
  end

  function automatic int unsigned sat16(input int unsigned v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_hold = '0; m_hold_v = 0; m_pend = 0; m_ant_last = 0;
    m_cyc = 0; m_id = 0; m_ant_n = 0; m_drop = 0; m_miss = 0; m_inject = 0;
  endtask

  task automatic m_step();
    bit fire, sel, ld, ant_ld, tick;
    packet_t p;
    fire = m_hold_v && i_en;
    if (fire) m_inject++;
    sel    = m_pend && (m_q.size() == 0 || !m_ant_last);
    ld     = (!m_hold_v || fire) && (sel || m_q.size() != 0);
    ant_ld = ld && sel;
    if (ld) begin
      if (sel) begin
        p = '0;
        p.ant    = 1'b1;
        p.x_dest = XW'(ant_x[m_ant_n % ant_x.size()]);
        p.y_dest = YW'(ant_y[m_ant_n % ant_y.size()]);
        m_ant_n++;
        m_ant_last = 1;
      end else begin
        p = m_q.pop_front();
        m_ant_last = 0;
      end
      p.x_source  = XW'(XL);
      p.y_source  = YW'(YL);
      p.id        = ID_W'(m_id);
      p.timestamp = TS_W'(m_cyc);
      m_id++;
      m_hold   = p;
      m_hold_v = 1;
    end else if (fire) begin
      m_hold_v = 0;
    end
    tick = (m_cyc % AP) == AP - 1;
    if (tick) begin
      if (m_pend && !ant_ld) m_miss++;
      m_pend = 1;
    end else if (ant_ld) begin
      m_pend = 0;
    end
    if (i_gen_val) begin
      if (m_q.size() < QD) begin
        p = '0;
        p.x_dest  = i_gen_data.x_dest;
        p.y_dest  = i_gen_data.y_dest;
        p.measure = i_gen_data.measure;
        m_q.push_back(p);
      end else begin
        m_drop++;
      end
    end
    m_cyc++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else          m_step();
  end

  // Compare DUT against the model every cycle out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      check("o_data_val", 256'(o_data_val), 256'(m_hold_v));
      if (m_hold_v) check("o_data", 256'(o_data), 256'(m_hold));
      check("o_full", 256'(o_full), 256'(m_q.size() == QD));
      check("o_drop_count", 256'(o_drop_count), 256'(sat16(m_drop)));
      check("o_ant_miss", 256'(o_ant_miss), 256'(sat16(m_miss)));
      check("o_inject_count", 256'(o_inject_count), 256'(m_inject));
    end
  end

  // Transfer log taken from the DUT
  packet_t xlog[$];
  always @(posedge clk) begin
    if (reset_n && o_data_val && i_en) xlog.push_back(o_data);
  end

  function automatic packet_t mk(input int unsigned i);
    packet_t p;
    p = '0;
    p.ant      = 1'b1;   // junk in fields the scheduler must ignore
    p.id       = 8'hAA;
    p.x_source = XW'(3);
    p.x_dest   = XW'((i + 1) % X_NODES);
    p.y_dest   = YW'((i + 2) % Y_NODES);
    p.measure  = MEAS_W'(16'h5A00 + i);
    return p;
  endfunction

  task automatic do_reset(input logic en);
    @(negedge clk);
    reset_n   = 1'b0;
    i_gen_val = 1'b0;
    i_en      = en;
    repeat (2) @(negedge clk);
    xlog.delete();
    reset_n = 1'b1;
  endtask

  task automatic push_n(input int unsigned n, input int unsigned base);
    for (int unsigned i = 0; i < n; i++) begin
      i_gen_val  = 1'b1;
      i_gen_data = mk(base + i);
      @(negedge clk);
    end
    i_gen_val = 1'b0;
  endtask

  initial begin
    int unsigned pairs, ants, self_hits;
    packet_t d0;

    // Idle ants: loads at edges 16 and 32
    do_reset(1'b1);
    repeat (40) @(negedge clk);
    check("idle_xfers", 256'(xlog.size()), 256'(2));
    if (xlog.size() >= 2) begin
      check("ant0_dest", 256'({xlog[0].ant, xlog[0].x_dest, xlog[0].y_dest}), 256'({1'b1, 2'd0, 2'd0}));
      check("ant0_id_ts", 256'({xlog[0].id, xlog[0].timestamp}), 256'({8'd0, 16'd16}));
      check("ant0_src", 256'({xlog[0].x_source, xlog[0].y_source}), 256'({2'd2, 2'd1}));
      check("ant1_dest", 256'({xlog[1].x_dest, xlog[1].y_dest}), 256'({2'd1, 2'd0}));
      check("ant1_id_ts", 256'({xlog[1].id, xlog[1].timestamp}), 256'({8'd1, 16'd32}));
    end
    check("idle_miss", 256'(o_ant_miss), 256'(0));

    // Backpressure fill: 6 pushes at edges 40..45 with i_en low
    i_en = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      i_gen_val  = 1'b1;
      i_gen_data = mk(i);
      @(negedge clk);
      check("full_after_push", 256'(o_full), 256'(i >= 4));
    end
    i_gen_val = 1'b0;
    d0 = mk(0);
    check("fill_drop", 256'(o_drop_count), 256'(1));
    check("fill_hold", 256'({o_data_val, o_data.ant, o_data.x_dest, o_data.id, o_data.timestamp}),
          256'({1'b1, 1'b0, d0.x_dest, 8'd2, 16'd41}));

    // Ant miss with output stuck: ant at 16, pending at 31, miss at 47
    do_reset(1'b0);
    repeat (47) @(negedge clk);
    check("miss_before", 256'(o_ant_miss), 256'(0));
    @(negedge clk);
    check("miss_after", 256'(o_ant_miss), 256'(1));

    // Full FIFO streaming: fill, then push and drain one per cycle
    do_reset(1'b0);
    push_n(5, 0);
    i_en = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      i_gen_val  = 1'b1;
      i_gen_data = mk(10 + i);
      @(negedge clk);
      check("stream_full", 256'(o_full), 256'(1));
    end
    i_gen_val = 1'b0;
    check("stream_inject", 256'(o_inject_count), 256'(6));
    check("stream_drop", 256'(o_drop_count), 256'(0));
    repeat (8) @(negedge clk);

    // Interleave: data waiting when the ant becomes pending
    do_reset(1'b0);
    push_n(4, 20);
    repeat (16) @(negedge clk);
    i_en = 1'b1;
    push_n(22, 30);
    pairs = 0; ants = 0;
    foreach (xlog[i]) begin
      if (xlog[i].ant) ants++;
      if (i > 0 && xlog[i].ant && xlog[i-1].ant) pairs++;
    end
    check("ilv_ant_count", 256'(ants), 256'(2));
    check("ilv_back_to_back", 256'(pairs), 256'(0));
    if (xlog.size() >= 3)
      check("ilv_order", 256'({xlog[0].ant, xlog[1].ant, xlog[2].ant, xlog[1].timestamp}),
            256'({1'b0, 1'b1, 1'b0, 16'd20}));

    // Destination walk over 16 ants
    do_reset(1'b1);
    repeat (260) @(negedge clk);
    check("walk_count", 256'(xlog.size()), 256'(16));
    self_hits = 0;
    foreach (xlog[i]) if (xlog[i].x_dest == XW'(XL) && xlog[i].y_dest == YW'(YL)) self_hits++;
    check("walk_self", 256'(self_hits), 256'(0));
    if (xlog.size() >= 16) begin
      check("walk_skip", 256'({xlog[5].x_dest, xlog[5].y_dest, xlog[6].x_dest, xlog[6].y_dest}),
            256'({2'd1, 2'd1, 2'd3, 2'd1}));
      check("walk_wrap", 256'({xlog[14].x_dest, xlog[14].y_dest, xlog[15].x_dest, xlog[15].y_dest}),
            256'({2'd3, 2'd3, 2'd0, 2'd0}));
    end

    // Asynchronous reset while holding a packet with 3 queued
    do_reset(1'b0);
    push_n(4, 40);
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs", 256'({o_data_val, o_full, o_drop_count, o_ant_miss, o_inject_count}), 256'(0));
    check("rst_data", 256'(o_data), 256'(0));
    @(negedge clk);
    xlog.delete();
    i_en = 1'b1;
    i_gen_val = 1'b1;
    i_gen_data = mk(7);
    reset_n = 1'b1;
    @(negedge clk);
    i_gen_val = 1'b0;
    repeat (3) @(negedge clk);
    d0 = mk(7);
    check("rst_xfers", 256'(xlog.size()), 256'(1));
    if (xlog.size() >= 1)
      check("rst_first", 256'({xlog[0].id, xlog[0].timestamp, xlog[0].x_dest, xlog[0].ant}),
            256'({8'd0, 16'd1, d0.x_dest, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
